// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, display-word layout and anode helper for the 4-digit 7-segment scan driver.
package seg7_scan_driver_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned WORD_W = DIGITS * NIB_W;
  localparam int unsigned DIG_W  = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [SEG_W-1:0]  SEG_OFF = 7'h7F;
  localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

  // Active-low segment codes {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] HEX_0 = 7'h40;
  localparam logic [SEG_W-1:0] HEX_1 = 7'h79;
  localparam logic [SEG_W-1:0] HEX_2 = 7'h24;
  localparam logic [SEG_W-1:0] HEX_3 = 7'h30;
  localparam logic [SEG_W-1:0] HEX_4 = 7'h19;
  localparam logic [SEG_W-1:0] HEX_5 = 7'h12;
  localparam logic [SEG_W-1:0] HEX_6 = 7'h02;
  localparam logic [SEG_W-1:0] HEX_7 = 7'h78;
  localparam logic [SEG_W-1:0] HEX_8 = 7'h00;
  localparam logic [SEG_W-1:0] HEX_9 = 7'h10;
  localparam logic [SEG_W-1:0] HEX_A = 7'h08;
  localparam logic [SEG_W-1:0] HEX_B = 7'h03;
  localparam logic [SEG_W-1:0] HEX_C = 7'h46;
  localparam logic [SEG_W-1:0] HEX_D = 7'h21;
  localparam logic [SEG_W-1:0] HEX_E = 7'h06;
  localparam logic [SEG_W-1:0] HEX_F = 7'h0E;

  typedef struct packed {
    logic [NIB_W-1:0] d3;
    logic [NIB_W-1:0] d2;
    logic [NIB_W-1:0] d1;
    logic [NIB_W-1:0] d0;
  } disp_word_t;

  function automatic logic [DIGITS-1:0] an_onehot_low(input logic [DIG_W-1:0] d);
    return ~(DIGITS'(1) << d);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Decoder-side and pin-side signals of the 7-segment scan driver.
interface seg7_scan_driver_if;
  import seg7_scan_driver_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              load;
  logic              blank;
  logic [DIGITS-1:0] dp_mask;
  logic [DIGITS-1:0] an;
  logic [SEG_W-1:0]  seg;
  logic              dp;
  logic              pending;
  logic              frame_tick;

  modport master (
    output data_in, load, blank, dp_mask,
    input  an, seg, dp, pending, frame_tick
  );

  modport slave (
    input  data_in, load, blank, dp_mask,
    output an, seg, dp, pending, frame_tick
  );
endinterface

// File: rtl/seg7_hex_encode.sv
// Combinational nibble to active-low 7-segment code.
module seg7_hex_encode
  import seg7_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'h0: seg_c = HEX_0;
      4'h1: seg_c = HEX_1;
      4'h2: seg_c = HEX_2;
      4'h3: seg_c = HEX_3;
      4'h4: seg_c = HEX_4;
      4'h5: seg_c = HEX_5;
      4'h6: seg_c = HEX_6;
      4'h7: seg_c = HEX_7;
      4'h8: seg_c = HEX_8;
      4'h9: seg_c = HEX_9;
      4'hA: seg_c = HEX_A;
      4'hB: seg_c = HEX_B;
      4'hC: seg_c = HEX_C;
      4'hD: seg_c = HEX_D;
      4'hE: seg_c = HEX_E;
      4'hF: seg_c = HEX_F;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed common-anode 7-segment driver with frame-aligned word update.
// Build option SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

  logic [CNT_W-1:0]  div_cnt;
  logic [DIG_W-1:0]  digit;
  disp_word_t        disp_reg;
  disp_word_t        pend_reg;
  logic              pend_valid;

  logic              slot_wrap_c;
  logic              frame_wrap_c;
  logic [NIB_W-1:0]  nibble_c;
  logic [SEG_W-1:0]  hex_c;
  logic              suppress_c;
  logic [DIGITS-1:0] an_nxt_c;
  logic [SEG_W-1:0]  seg_nxt_c;
  logic              dp_nxt_c;

  assign slot_wrap_c  = (div_cnt == DIV_LAST);
  assign frame_wrap_c = slot_wrap_c && (digit == DIG_W'(DIGITS - 1));

  // Slot divider and digit scan position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      digit   <= '0;
    end else if (slot_wrap_c) begin
      div_cnt <= '0;
      digit   <= digit + DIG_W'(1);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Word capture; the shown word only changes on the frame wrap so a scan is never mixed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
    end else if (bus.load && frame_wrap_c) begin
      disp_reg   <= disp_word_t'(bus.data_in);
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_reg   <= disp_word_t'(bus.data_in);
      pend_valid <= 1'b1;
    end else if (frame_wrap_c && pend_valid) begin
      disp_reg   <= pend_reg;
      pend_valid <= 1'b0;
    end
  end

  always_comb begin
    nibble_c = disp_reg.d0;
    case (digit)
      2'd0: nibble_c = disp_reg.d0;
      2'd1: nibble_c = disp_reg.d1;
      2'd2: nibble_c = disp_reg.d2;
      2'd3: nibble_c = disp_reg.d3;
      default: nibble_c = disp_reg.d0;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero
  always_comb begin
    suppress_c = 1'b0;
    case (digit)
      2'd3: suppress_c = (disp_reg.d3 == '0);
      2'd2: suppress_c = ({disp_reg.d3, disp_reg.d2} == '0);
      2'd1: suppress_c = ({disp_reg.d3, disp_reg.d2, disp_reg.d1} == '0);
      default: suppress_c = 1'b0;
    endcase
  end
`else
  assign suppress_c = 1'b0;
`endif

  seg7_hex_encode u_hex (
    .nibble (nibble_c),
    .seg_c  (hex_c)
  );

  // Suppressed digits keep their anode on only to show a requested decimal point
  always_comb begin
    an_nxt_c  = AN_OFF;
    seg_nxt_c = SEG_OFF;
    dp_nxt_c  = 1'b1;
    if (!bus.blank && (div_cnt >= GUARD_CNT)) begin
      if (!suppress_c) begin
        an_nxt_c  = an_onehot_low(digit);
        seg_nxt_c = hex_c;
        dp_nxt_c  = ~bus.dp_mask[digit];
      end else if (bus.dp_mask[digit]) begin
        an_nxt_c  = an_onehot_low(digit);
        dp_nxt_c  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= an_nxt_c;
      bus.seg        <= seg_nxt_c;
      bus.dp         <= dp_nxt_c;
      bus.frame_tick <= frame_wrap_c;
    end
  end

  assign bus.pending = pend_valid;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, GUARD=2 (32-cycle frame).
module tb_seg7_scan_driver;

  localparam int unsigned RD = 8;
  localparam int unsigned GD = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cyc counts rising edges since reset release; outputs at cycle n reflect counter state n-1
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic pulse_load(input logic [15:0] w);
    bus.data_in = w;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
  endtask

  task automatic chk_slot(input string tag, input int base, input logic [3:0] an_e,
                          input logic [6:0] seg_e, input logic dp_e);
    run_to(base + 2);
    chk({tag, "_guard_an"}, 16'(bus.an), 16'(4'hF));
    chk({tag, "_guard_dp"}, 16'(bus.dp), 16'(1'b1));
    run_to(base + 3);
    chk({tag, "_an"}, 16'(bus.an), 16'(an_e));
    chk({tag, "_seg"}, 16'(bus.seg), 16'(seg_e));
    chk({tag, "_dp"}, 16'(bus.dp), 16'(dp_e));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 16'(bus.an), 16'(4'hF));
    chk({tag, "_seg"}, 16'(bus.seg), 16'(7'h7F));
    chk({tag, "_dp"}, 16'(bus.dp), 16'(1'b1));
    chk({tag, "_pending"}, 16'(bus.pending), 16'(1'b0));
    chk({tag, "_tick"}, 16'(bus.frame_tick), 16'(1'b0));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.data_in = '0;
    bus.load    = 1'b0;
    bus.blank   = 1'b0;
    bus.dp_mask = '0;

    // Reset state and free-running scan of 0000
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc   = 0;
    run_to(1);
    chk("c1_an", 16'(bus.an), 16'(4'hF));
    chk_slot("f0d0", 0, 4'hE, 7'h40, 1'b1);
    run_to(8);
    chk("c8_an", 16'(bus.an), 16'(4'hE));
    run_to(9);
    chk("c9_an", 16'(bus.an), 16'(4'hF));
    chk_slot("f0d1", 8, 4'hD, 7'h40, 1'b1);
    chk_slot("f0d2", 16, 4'hB, 7'h40, 1'b1);
    chk_slot("f0d3", 24, 4'h7, 7'h40, 1'b1);
    run_to(31);
    chk("tick31", 16'(bus.frame_tick), 16'(1'b0));
    run_to(32);
    chk("tick32", 16'(bus.frame_tick), 16'(1'b1));
    run_to(33);
    chk("tick33", 16'(bus.frame_tick), 16'(1'b0));

    // Mid-frame load is held until the frame wrap
    run_to(40);
    pulse_load(16'h12AF);
    chk("pend41", 16'(bus.pending), 16'(1'b1));
    chk_slot("f1d1_old", 40, 4'hD, 7'h40, 1'b1);
    run_to(63);
    chk("pend63", 16'(bus.pending), 16'(1'b1));
    run_to(64);
    chk("pend64", 16'(bus.pending), 16'(1'b0));
    chk("tick64", 16'(bus.frame_tick), 16'(1'b1));
    chk_slot("f2d0", 64, 4'hE, 7'h0E, 1'b1);
    chk_slot("f2d1", 72, 4'hD, 7'h08, 1'b1);
    chk_slot("f2d2", 80, 4'hB, 7'h24, 1'b1);
    chk_slot("f2d3", 88, 4'h7, 7'h79, 1'b1);

    // Latest load wins, including a load on the wrap cycle itself
    run_to(100);
    pulse_load(16'h1111);
    run_to(110);
    pulse_load(16'h2222);
    chk("pend111", 16'(bus.pending), 16'(1'b1));
    run_to(127);
    pulse_load(16'h3333);
    chk("pend128", 16'(bus.pending), 16'(1'b0));
    chk("tick128", 16'(bus.frame_tick), 16'(1'b1));

    // Decimal point only on digit 2
    bus.dp_mask = 4'b0100;
    chk_slot("f4d0", 128, 4'hE, 7'h30, 1'b1);
    chk_slot("f4d1", 136, 4'hD, 7'h30, 1'b1);
    chk_slot("f4d2", 144, 4'hB, 7'h30, 1'b0);
    chk_slot("f4d3", 152, 4'h7, 7'h30, 1'b1);

    // Full blanked frame; counter keeps running
    run_to(159);
    bus.dp_mask = 4'b0000;
    bus.blank   = 1'b1;
    for (int d = 0; d < 4; d++) begin
      run_to(163 + 8 * d);
      chk("blank_an", 16'(bus.an), 16'(4'hF));
      chk("blank_seg", 16'(bus.seg), 16'(7'h7F));
    end
    run_to(191);
    chk("tick191", 16'(bus.frame_tick), 16'(1'b0));
    run_to(192);
    chk("tick192", 16'(bus.frame_tick), 16'(1'b1));
    bus.blank = 1'b0;
    chk_slot("f6d0", 192, 4'hE, 7'h30, 1'b1);

    // Leading-zero handling
    run_to(200);
    pulse_load(16'h00A0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk_slot("lz_a0_d0", 224, 4'hE, 7'h40, 1'b1);
    chk_slot("lz_a0_d1", 232, 4'hD, 7'h08, 1'b1);
    chk_slot("lz_a0_d2", 240, 4'hF, 7'h7F, 1'b1);
    chk_slot("lz_a0_d3", 248, 4'hF, 7'h7F, 1'b1);
`else
    chk_slot("lz_a0_d0", 224, 4'hE, 7'h40, 1'b1);
    chk_slot("lz_a0_d1", 232, 4'hD, 7'h08, 1'b1);
    chk_slot("lz_a0_d2", 240, 4'hB, 7'h40, 1'b1);
    chk_slot("lz_a0_d3", 248, 4'h7, 7'h40, 1'b1);
`endif
    run_to(250);
    pulse_load(16'h0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk_slot("lz_00_d0", 256, 4'hE, 7'h40, 1'b1);
    chk_slot("lz_00_d1", 264, 4'hF, 7'h7F, 1'b1);
    chk_slot("lz_00_d2", 272, 4'hF, 7'h7F, 1'b1);
    run_to(279);
    bus.dp_mask = 4'b1000;
    chk_slot("lz_00_d3dp", 280, 4'h7, 7'h7F, 1'b0);
`else
    chk_slot("lz_00_d0", 256, 4'hE, 7'h40, 1'b1);
    chk_slot("lz_00_d1", 264, 4'hD, 7'h40, 1'b1);
    chk_slot("lz_00_d2", 272, 4'hB, 7'h40, 1'b1);
    run_to(279);
    bus.dp_mask = 4'b1000;
    chk_slot("lz_00_d3dp", 280, 4'h7, 7'h40, 1'b0);
`endif
    bus.dp_mask = 4'b0000;

    // Asynchronous reset with a word pending
    run_to(300);
    pulse_load(16'h5555);
    chk("pend301", 16'(bus.pending), 16'(1'b1));
    run_to(302);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    chk("arst_pend_rel", 16'(bus.pending), 16'(1'b0));
    chk_slot("arst_f0d0", 0, 4'hE, 7'h40, 1'b1);
    run_to(33);
    chk("arst_pend33", 16'(bus.pending), 16'(1'b0));
    chk_slot("arst_f1d0", 32, 4'hE, 7'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
